// File: rtl/fft_stage_seq_pkg.sv
// Shared constants and helpers for the FFT input sequencer: data widths,
// the legal log2(N) range and the FSM state encoding.
package fft_stage_seq_pkg;

  localparam int MAN_W_DEF = 16;
  localparam int EXP_W_DEF = 6;
  localparam int LDN_W     = 4;
  localparam int CNT_W     = 11;

  localparam logic [LDN_W-1:0] LDN_MIN = 4'd2;
  localparam logic [LDN_W-1:0] LDN_MAX = 4'd11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic ldn_legal(input logic [LDN_W-1:0] ldn);
    return (ldn >= LDN_MIN) && (ldn <= LDN_MAX);
  endfunction

  // Index of the last sample of a block, N-1 with N = 1 << ldn.
  function automatic logic [CNT_W-1:0] last_idx(input logic [LDN_W-1:0] ldn);
    logic [CNT_W:0] n;
    n = (CNT_W+1)'(1) << ldn;
    return n[CNT_W-1:0] - CNT_W'(1);
  endfunction

endpackage

// File: rtl/fft_cfg_shadow.sv
// Pending transform-size register: accepts only legal log2(N) writes and
// pulses an error flag for anything outside the supported range.
module fft_cfg_shadow
  import fft_stage_seq_pkg::*;
(
  input  logic             clk_sys,
  input  logic             rst_sys_n,
  input  logic [LDN_W-1:0] i_cfg_ldn,
  input  logic             i_cfg_load,
  output logic [LDN_W-1:0] o_pending_ldn,
  output logic             o_cfg_err
);

  logic [LDN_W-1:0] r_pending_ldn;
  logic             r_cfg_err;
  logic             w_legal;

  assign w_legal = ldn_legal(i_cfg_ldn);

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_pending_ldn <= LDN_MAX;
      r_cfg_err     <= 1'b0;
    end else begin
      r_cfg_err <= i_cfg_load & ~w_legal;
      if (i_cfg_load && w_legal) r_pending_ldn <= i_cfg_ldn;
    end
  end

  assign o_pending_ldn = r_pending_ldn;
  assign o_cfg_err     = r_cfg_err;

endmodule

// File: rtl/fft_stage_seq.sv
// Block sequencer at the FFT input: frames blocks, generates pair/block sync,
// shadows log2(N) per block and flags short, long and stray samples.
//
// state | meaning
// IDLE  | waiting for a valid sample with block_sync_i
// RUN   | inside a block, counting samples up to N-1
module fft_stage_seq
  import fft_stage_seq_pkg::*;
#(
  parameter int MAN_WIDTH = MAN_W_DEF,
  parameter int EXP_WIDTH = EXP_W_DEF
) (
  input  logic                 clk_sys,
  input  logic                 rst_sys_n,
  input  logic [LDN_W-1:0]     cfg_ldn_i,
  input  logic                 cfg_load_i,
  input  logic                 block_sync_i,
  input  logic                 data_val_i,
  input  logic [MAN_WIDTH-1:0] data_real_i,
  input  logic [MAN_WIDTH-1:0] data_imag_i,
  input  logic [EXP_WIDTH-1:0] data_exp_i,
  output logic                 block_sync_o,
  output logic                 stage_sync_o,
  output logic                 data_val_o,
  output logic [MAN_WIDTH-1:0] data_real_o,
  output logic [MAN_WIDTH-1:0] data_imag_o,
  output logic [EXP_WIDTH-1:0] data_exp_o,
  output logic [LDN_W-1:0]     ldn_rg_o,
  output logic                 busy_o,
  output logic                 blk_done_o,
  output logic                 err_short_o,
  output logic                 err_long_o,
  output logic                 cfg_err_o
);

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt, w_last;
  logic [LDN_W-1:0]     r_ldn_rg, w_pending_ldn;
  logic                 w_start, w_fwd, w_ss, w_done, w_err_short, w_err_long;
  logic                 r_val, r_bs, r_ss, r_busy, r_done, r_err_short, r_err_long;
  logic [MAN_WIDTH-1:0] r_re, r_im;
  logic [EXP_WIDTH-1:0] r_exp;

  fft_cfg_shadow u_cfg_shadow (
    .clk_sys      (clk_sys),
    .rst_sys_n    (rst_sys_n),
    .i_cfg_ldn    (cfg_ldn_i),
    .i_cfg_load   (cfg_load_i),
    .o_pending_ldn(w_pending_ldn),
    .o_cfg_err    (cfg_err_o)
  );

  assign w_last = last_idx(r_ldn_rg);

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A block start from either state is the same event; from RUN it is a restart.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_start) begin
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = CNT_W'(1);
    end else if (w_fwd) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
      if (w_done) begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    end
  end

  always_comb begin
    w_start     = data_val_i & block_sync_i;
    w_fwd       = 1'b0;
    w_ss        = 1'b0;
    w_done      = 1'b0;
    w_err_short = 1'b0;
    w_err_long  = 1'b0;
    if (data_val_i) begin
      if (block_sync_i) begin
        w_fwd       = 1'b1;
        w_ss        = 1'b1;
        w_err_short = (r_state == ST_RUN);
      end else if (r_state == ST_RUN) begin
        w_fwd  = 1'b1;
        w_ss   = ~r_cnt[0];
        w_done = (r_cnt == w_last);
      end else begin
        w_err_long = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_val       <= 1'b0;
      r_bs        <= 1'b0;
      r_ss        <= 1'b0;
      r_re        <= '0;
      r_im        <= '0;
      r_exp       <= '0;
      r_ldn_rg    <= LDN_MAX;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
    end else begin
      r_val       <= w_fwd;
      r_bs        <= w_start;
      r_ss        <= w_ss;
      r_re        <= w_fwd ? data_real_i : '0;
      r_im        <= w_fwd ? data_imag_i : '0;
      r_exp       <= w_fwd ? data_exp_i : '0;
      r_busy      <= (r_state == ST_RUN);
      r_done      <= w_done;
      r_err_short <= w_err_short;
      r_err_long  <= w_err_long;
      if (w_start) r_ldn_rg <= w_pending_ldn;
    end
  end

  assign data_val_o   = r_val;
  assign block_sync_o = r_bs;
  assign stage_sync_o = r_ss;
  assign data_real_o  = r_re;
  assign data_imag_o  = r_im;
  assign data_exp_o   = r_exp;
  assign ldn_rg_o     = r_ldn_rg;
  assign busy_o       = r_busy;
  assign blk_done_o   = r_done;
  assign err_short_o  = r_err_short;
  assign err_long_o   = r_err_long;

endmodule

// File: tb/tb_fft_stage_seq.sv
// Directed bench for fft_stage_seq: framing, gaps, restarts, stray samples,
// configuration shadowing and mid-block reset.
module tb_fft_stage_seq;

  logic        clk_sys = 1'b0;
  logic        rst_sys_n = 1'b0;
  logic [3:0]  cfg_ldn_i = '0;
  logic        cfg_load_i = 1'b0;
  logic        block_sync_i = 1'b0;
  logic        data_val_i = 1'b0;
  logic [15:0] data_real_i = '0;
  logic [15:0] data_imag_i = '0;
  logic [5:0]  data_exp_i = '0;
  logic        block_sync_o, stage_sync_o, data_val_o;
  logic [15:0] data_real_o, data_imag_o;
  logic [5:0]  data_exp_o;
  logic [3:0]  ldn_rg_o;
  logic        busy_o, blk_done_o, err_short_o, err_long_o, cfg_err_o;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  fft_stage_seq dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
    .cfg_ldn_i(cfg_ldn_i), .cfg_load_i(cfg_load_i),
    .block_sync_i(block_sync_i), .data_val_i(data_val_i),
    .data_real_i(data_real_i), .data_imag_i(data_imag_i), .data_exp_i(data_exp_i),
    .block_sync_o(block_sync_o), .stage_sync_o(stage_sync_o), .data_val_o(data_val_o),
    .data_real_o(data_real_o), .data_imag_o(data_imag_o), .data_exp_o(data_exp_o),
    .ldn_rg_o(ldn_rg_o), .busy_o(busy_o), .blk_done_o(blk_done_o),
    .err_short_o(err_short_o), .err_long_o(err_long_o), .cfg_err_o(cfg_err_o)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [15:0] re_of(input int i);
    return 16'(i * 37 + 5);
  endfunction
  function automatic logic [15:0] im_of(input int i);
    return 16'(65535 - i);
  endfunction
  function automatic logic [5:0] ex_of(input int i);
    return 6'(i ^ 21);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input bit val, bs, ss, done, es, el, input int idx);
    chk({tag, "_val"},   data_val_o,   val);
    chk({tag, "_bs"},    block_sync_o, bs);
    chk({tag, "_ss"},    stage_sync_o, ss);
    chk({tag, "_done"},  blk_done_o,   done);
    chk({tag, "_eshrt"}, err_short_o,  es);
    chk({tag, "_elong"}, err_long_o,   el);
    chk({tag, "_re"},    data_real_o,  val ? re_of(idx) : 16'd0);
    chk({tag, "_im"},    data_imag_o,  val ? im_of(idx) : 16'd0);
    chk({tag, "_ex"},    data_exp_o,   val ? ex_of(idx) : 6'd0);
  endtask

  // One input cycle; outputs for this input are sampled 1 ns after the edge.
  task automatic drive(input bit val, input bit sync, input int idx,
                       input bit ld = 1'b0, input logic [3:0] ldn = 4'd0);
    @(negedge clk_sys);
    data_val_i   = val;
    block_sync_i = sync;
    data_real_i  = re_of(idx);
    data_imag_i  = im_of(idx);
    data_exp_i   = ex_of(idx);
    cfg_load_i   = ld;
    cfg_ldn_i    = ldn;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_val"},  data_val_o,   0);
    chk({tag, "_bs"},   block_sync_o, 0);
    chk({tag, "_ss"},   stage_sync_o, 0);
    chk({tag, "_re"},   data_real_o,  0);
    chk({tag, "_im"},   data_imag_o,  0);
    chk({tag, "_ex"},   data_exp_o,   0);
    chk({tag, "_ldn"},  ldn_rg_o,     11);
    chk({tag, "_busy"}, busy_o,       0);
    chk({tag, "_done"}, blk_done_o,   0);
    chk({tag, "_es"},   err_short_o,  0);
    chk({tag, "_el"},   err_long_o,   0);
    chk({tag, "_cfge"}, cfg_err_o,    0);
  endtask

  initial begin
    #12;
    chk_reset("por");
    @(negedge clk_sys);
    rst_sys_n = 1'b1;

    // legal write, then two illegal ones that must not overwrite it
    drive(0, 0, 0, 1, 4'd4);
    chk("cfg4_err", cfg_err_o, 0);
    chk("cfg4_ldn", ldn_rg_o, 11);
    drive(0, 0, 0, 1, 4'd12);
    chk("cfg12_err", cfg_err_o, 1);
    chk("cfg12_ldn", ldn_rg_o, 11);
    drive(0, 0, 0, 1, 4'd1);
    chk("cfg1_err", cfg_err_o, 1);
    drive(0, 0, 0);
    chk("cfg_err_clr", cfg_err_o, 0);

    // ldn=4 contiguous block
    for (int i = 0; i < 16; i++) begin
      drive(1, i == 0, i);
      chk_out("b1", 1, i == 0, ~i[0], i == 15, 0, 0, i);
      chk("b1_busy", busy_o, i != 0);
      chk("b1_ldn", ldn_rg_o, 4);
    end
    drive(0, 0, 0);
    chk_out("b1_idle", 0, 0, 0, 0, 0, 0, 0);
    chk("b1_busy_fall", busy_o, 0);

    // stray samples outside a block
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 50 + i);
      chk_out("long", 0, 0, 0, 0, 0, 1, 0);
      chk("long_busy", busy_o, 0);
    end
    drive(0, 0, 0, 1, 4'd5);
    chk_out("long_idle", 0, 0, 0, 0, 0, 0, 0);

    // ldn=5 block with gaps; ldn=4 written mid-block applies to the next block
    for (int i = 0; i < 32; i++) begin
      if (i % 5 == 3) begin
        drive(0, 0, 0);
        chk_out("gap", 0, 0, 0, 0, 0, 0, 0);
        chk("gap_busy", busy_o, 1);
      end
      drive(1, i == 0, i, i == 20, 4'd4);
      chk_out("b5", 1, i == 0, ~i[0], i == 31, 0, 0, i);
      chk("b5_ldn", ldn_rg_o, 5);
    end

    // back-to-back start, then restart at index 10
    drive(1, 1, 100);
    chk_out("b2b", 1, 1, 1, 0, 0, 0, 100);
    chk("b2b_ldn", ldn_rg_o, 4);
    for (int i = 1; i < 10; i++) begin
      drive(1, 0, 100 + i);
      chk_out("rs_pre", 1, 0, ~i[0], 0, 0, 0, 100 + i);
    end
    chk("rs_busy", busy_o, 1);
    drive(1, 1, 110);
    chk_out("rs_hit", 1, 1, 1, 0, 1, 0, 110);
    for (int j = 1; j < 16; j++) begin
      drive(1, 0, 110 + j);
      chk_out("rs_post", 1, 0, ~j[0], j == 15, 0, 0, 110 + j);
    end

    // cfg write coinciding with start applies to the following block
    drive(1, 1, 200, 1, 4'd7);
    chk_out("co_start", 1, 1, 1, 0, 0, 0, 200);
    chk("co_ldn", ldn_rg_o, 4);
    for (int j = 1; j < 16; j++) begin
      drive(1, 0, 200 + j);
      chk_out("co", 1, 0, ~j[0], j == 15, 0, 0, 200 + j);
    end
    drive(0, 0, 0);
    chk("co_cfge", cfg_err_o, 0);

    // ldn=7 block spans 128 samples
    for (int i = 0; i < 128; i++) begin
      drive(1, i == 0, 300 + i);
      chk_out("b7", 1, i == 0, ~i[0], i == 127, 0, 0, 300 + i);
      chk("b7_ldn", ldn_rg_o, 7);
    end
    drive(0, 0, 0);
    chk("b7_busy_fall", busy_o, 0);

    // reset in the middle of a block
    for (int i = 0; i < 5; i++) begin
      drive(1, i == 0, 500 + i);
      chk_out("pre_rst", 1, i == 0, ~i[0], 0, 0, 0, 500 + i);
    end
    @(negedge clk_sys);
    data_val_i = 1'b1;
    block_sync_i = 1'b0;
    rst_sys_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    @(posedge clk_sys);
    #1;
    chk_reset("mid_rst_hold");
    @(negedge clk_sys);
    data_val_i = 1'b0;
    rst_sys_n = 1'b1;

    drive(0, 0, 0, 1, 4'd4);
    chk("post_rst_ldn", ldn_rg_o, 11);
    for (int i = 0; i < 16; i++) begin
      drive(1, i == 0, 600 + i);
      chk_out("post_rst", 1, i == 0, ~i[0], i == 15, 0, 0, 600 + i);
      chk("post_rst_ldn4", ldn_rg_o, 4);
    end
    drive(0, 0, 0);
    chk_out("final_idle", 0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
